atm_pin_verifier: RTL and testbench

Keypad-side PIN verification unit for the ATM controller. It opens an entry session when the controller accepts a card, collects BCD digits from the keypad, and compares them against the PIN read from the card. It returns a one-cycle `pin_entered`/`pin_correct` verdict to the controller's PIN-check state. Consecutive failures are counted across sessions, and the unit locks out after a limit.

---
 rtl/atm_pin_if.sv | 32 +++
 rtl/atm_pin_verifier.sv | 141 ++++++++++++++
 tb/tb_atm_pin_verifier.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/atm_pin_if.sv
// Keypad/controller bundle for the ATM PIN verifier.
// The controller side is the master; the verifier is the slave.
interface atm_pin_if #(
  parameter int PIN_DIGITS = 4
);
  logic                    session_start;
  logic                    session_end;
  logic [4*PIN_DIGITS-1:0] card_pin;
  logic                    key_valid;
  logic [3:0]              key_code;
  logic                    admin_unlock;
  logic                    pin_entered;
  logic                    pin_correct;
  logic                    locked;
  logic [1:0]              fail_count;
  logic [3:0]              digit_count;
  logic                    collecting;

  modport master (
    output session_start, session_end, card_pin,
    output key_valid, key_code, admin_unlock,
    input  pin_entered, pin_correct, locked,
    input  fail_count, digit_count, collecting
  );

  modport slave (
    input  session_start, session_end, card_pin,
    input  key_valid, key_code, admin_unlock,
    output pin_entered, pin_correct, locked,
    output fail_count, digit_count, collecting
  );
endinterface

// File: rtl/atm_pin_verifier.sv
// Keypad PIN collection and verification with a
// cross-session failure counter and lockout.
module atm_pin_verifier #(
  parameter int PIN_DIGITS     = 4,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic     clk,
  input logic     reset,
  atm_pin_if.slave bus
);
  localparam int W  = 4*PIN_DIGITS;
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [1:0]    MAXF  = 2'(MAX_ATTEMPTS);
  localparam logic [3:0]    FULL  = 4'(PIN_DIGITS);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES-1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_LOCKED
  } state_t;

  state_t        r_state;
  logic [W-1:0]  r_entry;
  logic [W-1:0]  r_pin;
  logic [CW-1:0] r_idle;
  logic [1:0]    r_fail;
  logic [3:0]    r_digits;
  logic          r_entered;
  logic          r_correct;

  logic          w_digit;
  logic          w_clear;
  logic          w_enter;
  logic          w_full;
  logic          w_timeout;
  logic          w_verdict;
  logic          w_ok;
  logic [1:0]    w_fail_inc;
  logic [1:0]    w_fail_nx;
  logic [W-1:0]  w_shift;

  assign w_digit    = bus.key_valid && (bus.key_code <= 4'd9);
  assign w_clear    = bus.key_valid && (bus.key_code == 4'hA);
  assign w_enter    = bus.key_valid && (bus.key_code == 4'hB);
  assign w_full     = (r_digits == FULL);
  assign w_timeout  = !bus.key_valid && (r_idle == TLAST);
  assign w_shift    = (r_entry << 4) | W'(bus.key_code);
  assign w_fail_inc = (r_fail >= MAXF) ? MAXF : r_fail + 2'd1;

  // A timeout is always a wrong verdict, whatever was typed.
  assign w_verdict = (r_state == S_COLLECT) && !bus.admin_unlock
                  && !bus.session_end
                  && (w_timeout || (w_enter && w_full));
  assign w_ok      = !w_timeout && (r_entry == r_pin);
  assign w_fail_nx = w_ok ? 2'd0 : w_fail_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_entry   <= '0;
      r_pin     <= '0;
      r_idle    <= '0;
      r_fail    <= '0;
      r_digits  <= '0;
      r_entered <= 1'b0;
      r_correct <= 1'b0;
    end else begin
      r_entered <= 1'b0;
      r_correct <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.admin_unlock) r_fail <= '0;
          if (bus.session_start && !bus.session_end) begin
            r_pin    <= bus.card_pin;
            r_entry  <= '0;
            r_digits <= '0;
            r_idle   <= '0;
            r_state  <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (bus.admin_unlock) begin
            r_fail <= '0;
            if (bus.key_valid) r_idle <= '0;
          end else if (bus.session_end) begin
            r_entry  <= '0;
            r_digits <= '0;
            r_idle   <= '0;
            r_state  <= S_IDLE;
          end else if (w_verdict) begin
            r_entered <= 1'b1;
            r_correct <= w_ok;
            r_fail    <= w_fail_nx;
            r_entry   <= '0;
            r_pin     <= '0;
            r_digits  <= '0;
            r_idle    <= '0;
            r_state   <= (w_fail_nx == MAXF) ? S_LOCKED : S_IDLE;
          end else if (bus.key_valid) begin
            r_idle <= '0;
            unique case (1'b1)
              w_digit: begin
                if (!w_full) begin
                  r_entry  <= w_shift;
                  r_digits <= r_digits + 4'd1;
                end
              end
              w_clear: begin
                r_entry  <= '0;
                r_digits <= '0;
              end
              default: ;
            endcase
          end else begin
            r_idle <= r_idle + CW'(1);
          end
        end
        S_LOCKED: begin
          if (bus.admin_unlock) begin
            r_fail  <= '0;
            r_state <= S_IDLE;
          end else if (bus.session_start && !bus.session_end) begin
            r_entered <= 1'b1;
            r_correct <= 1'b0;
            r_fail    <= w_fail_inc;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.pin_entered = r_entered;
  assign bus.pin_correct = r_correct;
  assign bus.locked      = (r_state == S_LOCKED);
  assign bus.collecting  = (r_state == S_COLLECT);
  assign bus.fail_count  = r_fail;
  assign bus.digit_count = r_digits;
endmodule

// File: tb/tb_atm_pin_verifier.sv
// Bench for atm_pin_verifier: session vector table with a
// verdict scoreboard, plus timeout/abort/reset sequences.
module tb_atm_pin_verifier;
  localparam int T = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  atm_pin_if #(.PIN_DIGITS(4)) bus();

  atm_pin_verifier #(
    .PIN_DIGITS(4),
    .MAX_ATTEMPTS(3),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [15:0] pin;
    bit          lv;
    int          nk;
    logic [39:0] keys;
    logic [3:0]  dc;
    bit          en;
    bit          ev;
    bit          ec;
    logic [1:0]  fc;
    bit          lk;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  bit   exp_q[$];
  vec_t tv[10];

  function automatic vec_t mk(
    logic [15:0] pin, bit lv, int nk, logic [39:0] keys,
    logic [3:0] dc, bit en, bit ev, bit ec,
    logic [1:0] fc, bit lk);
    vec_t v;
    v.pin = pin; v.lv = lv; v.nk = nk; v.keys = keys;
    v.dc = dc; v.en = en; v.ev = ev; v.ec = ec;
    v.fc = fc; v.lk = lk;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] k);
    bus.key_valid = 1'b1;
    bus.key_code  = k;
    tick();
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
  endtask

  task automatic start(input logic [15:0] pin);
    bus.session_start = 1'b1;
    bus.card_pin      = pin;
    tick();
    bus.session_start = 1'b0;
  endtask

  // Scoreboard: every verdict strobe must match a queued expectation.
  always @(negedge clk) begin
    bit e;
    if (bus.pin_entered === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL verdict_unexpected: got strobe correct=%0b want none",
                 bus.pin_correct);
      end else begin
        e = exp_q.pop_front();
        if (bus.pin_correct !== e) begin
          n_err++;
          $display("FAIL verdict_value: got %0b want %0b",
                   bus.pin_correct, e);
        end
      end
    end else if (bus.pin_correct !== 1'b0 && reset === 1'b0) begin
      n_err++;
      $display("FAIL correct_idle: got %0b want 0", bus.pin_correct);
    end
  end

  initial begin
    bit seen;
    reset             = 1'b1;
    bus.session_start = 1'b0;
    bus.session_end   = 1'b0;
    bus.card_pin      = '0;
    bus.key_valid     = 1'b0;
    bus.key_code      = 4'h0;
    bus.admin_unlock  = 1'b0;

    tv[0] = mk(16'h1234, 1'b0, 4, 40'h1234, 4'd4,
               1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
    tv[1] = mk(16'h1234, 1'b0, 9, 40'h129A12345, 4'd4,
               1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
    tv[2] = mk(16'h0000, 1'b0, 4, 40'h0000, 4'd4,
               1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
    tv[3] = mk(16'h9876, 1'b0, 6, 40'h98C7F6, 4'd4,
               1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
    tv[4] = mk(16'h1234, 1'b0, 4, 40'h1235, 4'd4,
               1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
    tv[5] = mk(16'h1234, 1'b0, 4, 40'h1234, 4'd4,
               1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
    tv[6] = mk(16'h1234, 1'b0, 4, 40'h9999, 4'd4,
               1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
    tv[7] = mk(16'h1234, 1'b0, 4, 40'h9999, 4'd4,
               1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
    tv[8] = mk(16'h1234, 1'b0, 4, 40'h9999, 4'd4,
               1'b1, 1'b1, 1'b0, 2'd3, 1'b1);
    tv[9] = mk(16'h1234, 1'b1, 4, 40'h1234, 4'd0,
               1'b1, 1'b0, 1'b0, 2'd3, 1'b1);

    tick();
    tick();
    chk("rst_entered", 32'(bus.pin_entered), 32'd0);
    chk("rst_correct", 32'(bus.pin_correct), 32'd0);
    chk("rst_locked", 32'(bus.locked), 32'd0);
    chk("rst_fail", 32'(bus.fail_count), 32'd0);
    chk("rst_digits", 32'(bus.digit_count), 32'd0);
    chk("rst_coll", 32'(bus.collecting), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      if (tv[i].lv) exp_q.push_back(1'b0);
      start(tv[i].pin);
      for (int j = 0; j < tv[i].nk; j++)
        key(tv[i].keys[4*(tv[i].nk-1-j) +: 4]);
      chk($sformatf("v%0d_digits", i),
          32'(bus.digit_count), 32'(tv[i].dc));
      if (tv[i].en) begin
        if (tv[i].ev) exp_q.push_back(tv[i].ec);
        key(4'hB);
      end
      tick();
      tick();
      chk($sformatf("v%0d_fail", i),
          32'(bus.fail_count), 32'(tv[i].fc));
      chk($sformatf("v%0d_locked", i),
          32'(bus.locked), 32'(tv[i].lk));
      chk($sformatf("v%0d_coll", i), 32'(bus.collecting), 32'd0);
      chk($sformatf("v%0d_pending", i), 32'(exp_q.size()), 32'd0);
    end

    bus.admin_unlock = 1'b1;
    tick();
    bus.admin_unlock = 1'b0;
    chk("unlock_locked", 32'(bus.locked), 32'd0);
    chk("unlock_fail", 32'(bus.fail_count), 32'd0);
    chk("unlock_coll", 32'(bus.collecting), 32'd0);

    start(16'h1234);
    key(4'h1);
    key(4'h2);
    key(4'hB);
    seen = 1'b0;
    for (int i = 1; i < T; i++) begin
      tick();
      if (bus.pin_entered === 1'b1) seen = 1'b1;
      if (i == 2) begin
        chk("short_enter_digits", 32'(bus.digit_count), 32'd2);
        chk("short_enter_coll", 32'(bus.collecting), 32'd1);
        chk("short_enter_fail", 32'(bus.fail_count), 32'd0);
      end
    end
    chk("timeout_early", 32'(seen), 32'd0);
    exp_q.push_back(1'b0);
    tick();
    chk("timeout_strobe", 32'(bus.pin_entered), 32'd1);
    chk("timeout_value", 32'(bus.pin_correct), 32'd0);
    tick();
    chk("timeout_fail", 32'(bus.fail_count), 32'd1);
    chk("timeout_coll", 32'(bus.collecting), 32'd0);

    start(16'h1234);
    key(4'h1);
    key(4'h2);
    key(4'h3);
    chk("abort_pre_digits", 32'(bus.digit_count), 32'd3);
    bus.session_end = 1'b1;
    bus.key_valid   = 1'b1;
    bus.key_code    = 4'h4;
    tick();
    bus.session_end = 1'b0;
    bus.key_valid   = 1'b0;
    chk("abort_digits", 32'(bus.digit_count), 32'd0);
    chk("abort_coll", 32'(bus.collecting), 32'd0);
    tick();
    chk("abort_fail", 32'(bus.fail_count), 32'd1);

    start(16'h1234);
    for (int j = 0; j < 4; j++) key(4'h9);
    exp_q.push_back(1'b0);
    key(4'hB);
    tick();
    chk("pre_rst_fail", 32'(bus.fail_count), 32'd2);
    start(16'h1234);
    key(4'h1);
    key(4'h2);
    chk("pre_rst_digits", 32'(bus.digit_count), 32'd2);
    reset = 1'b1;
    tick();
    chk("mid_rst_entered", 32'(bus.pin_entered), 32'd0);
    chk("mid_rst_locked", 32'(bus.locked), 32'd0);
    chk("mid_rst_fail", 32'(bus.fail_count), 32'd0);
    chk("mid_rst_digits", 32'(bus.digit_count), 32'd0);
    chk("mid_rst_coll", 32'(bus.collecting), 32'd0);
    reset = 1'b0;
    tick();

    start(16'h4321);
    key(4'h4);
    key(4'h3);
    key(4'h2);
    key(4'h1);
    exp_q.push_back(1'b1);
    key(4'hB);
    chk("post_rst_strobe", 32'(bus.pin_entered), 32'd1);
    tick();
    tick();
    chk("post_rst_fail", 32'(bus.fail_count), 32'd0);
    chk("final_pending", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
